// File: rtl/traffic_sensor_unit.sv
// Two-lane vehicle detector: synchronises and debounces loop inputs, queues arrivals,
// and drains each queue at a fixed rate while that lane's green lamp is lit.
module traffic_sensor_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int QUEUE_W         = 4,
    parameter int DEPART_CYCLES   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               loop_a,
    input  logic               loop_b,
    input  logic               Ga,
    input  logic               Gb,
    input  logic               clr_ovf,
    output logic               Ta,
    output logic               Tb,
    output logic [QUEUE_W-1:0] qa,
    output logic [QUEUE_W-1:0] qb,
    output logic               ovf_a,
    output logic               ovf_b
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(DEPART_CYCLES + 1);
    localparam logic [QUEUE_W-1:0] Q_MAX = '1;

    logic [1:0]              loop_in;
    logic [1:0]              green;
    logic [1:0]              t_lane;
    logic [1:0]              ovf_lane;
    logic [1:0][QUEUE_W-1:0] q_lane;

    assign loop_in = {loop_b, loop_a};
    assign green   = {Gb, Ga};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic               s1_reg;
            logic               s2_reg;
            logic               filt_reg;
            logic               filt_d_reg;
            logic               t_reg;
            logic               ovf_reg;
            logic [DW-1:0]      dcnt_reg;
            logic [PW-1:0]      pcnt_reg;
            logic [QUEUE_W-1:0] q_reg;
            logic [QUEUE_W-1:0] q_next;
            logic               arr;
            logic               draining;
            logic               dep;

            // Simultaneous arrival and departure cancel; a full queue drops the arrival.
            always_comb begin
                arr      = filt_reg & ~filt_d_reg;
                draining = green[gi] && (q_reg != '0);
                dep      = draining && (pcnt_reg == PW'(DEPART_CYCLES - 1));
                q_next   = q_reg;
                if (arr && !dep) begin
                    if (q_reg != Q_MAX)
                        q_next = q_reg + QUEUE_W'(1);
                end else if (dep && !arr) begin
                    q_next = q_reg - QUEUE_W'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_reg     <= 1'b0;
                    s2_reg     <= 1'b0;
                    filt_reg   <= 1'b0;
                    filt_d_reg <= 1'b0;
                    dcnt_reg   <= '0;
                    pcnt_reg   <= '0;
                    q_reg      <= '0;
                    t_reg      <= 1'b0;
                    ovf_reg    <= 1'b0;
                end else begin
                    s1_reg <= loop_in[gi];
                    s2_reg <= s1_reg;

                    if (s2_reg == filt_reg) begin
                        dcnt_reg <= '0;
                    end else if (dcnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
                        filt_reg <= s2_reg;
                        dcnt_reg <= '0;
                    end else begin
                        dcnt_reg <= dcnt_reg + DW'(1);
                    end
                    filt_d_reg <= filt_reg;

                    // Losing green (or an empty queue) discards partial departure progress.
                    if (!draining || dep)
                        pcnt_reg <= '0;
                    else
                        pcnt_reg <= pcnt_reg + PW'(1);

                    q_reg <= q_next;
                    t_reg <= (q_next != '0);

                    if (arr && !dep && (q_reg == Q_MAX))
                        ovf_reg <= 1'b1;
                    else if (clr_ovf)
                        ovf_reg <= 1'b0;
                end
            end

            assign q_lane[gi]   = q_reg;
            assign t_lane[gi]   = t_reg;
            assign ovf_lane[gi] = ovf_reg;
        end
    endgenerate

    assign qa    = q_lane[0];
    assign qb    = q_lane[1];
    assign Ta    = t_lane[0];
    assign Tb    = t_lane[1];
    assign ovf_a = ovf_lane[0];
    assign ovf_b = ovf_lane[1];

endmodule

// File: doc/traffic_sensor_unit.md
Name: traffic_sensor_unit

Overview:
Vehicle-detection front end that produces the per-direction traffic-present requests Ta/Tb consumed by the intersection light controller. It closes the loop on the controller's green-lamp outputs Ga/Gb. For each of two lanes (A and B) it synchronises and debounces a raw inductive-loop input, counts arrivals into a saturating queue, and drains that queue at a fixed rate while the lane's green lamp is lit. Ta/Tb stay asserted while vehicles are queued.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive mismatching samples required before the filtered loop level changes (>=1)
QUEUE_W, 4, queue counter width; queue saturates at 2^QUEUE_W-1
DEPART_CYCLES, 8, green cycles needed to discharge one queued vehicle (>=1)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
loop_a  input  1  raw lane-A loop detector, asynchronous to clk
loop_b  input  1  raw lane-B loop detector, asynchronous to clk
Ga  input  1  lane-A green lamp from light controller
Gb  input  1  lane-B green lamp from light controller
clr_ovf  input  1  synchronous clear of both overflow flags
Ta  output  1  lane-A traffic request, registered
Tb  output  1  lane-B traffic request, registered
qa  output  QUEUE_W  lane-A queue count, registered
qb  output  QUEUE_W  lane-B queue count, registered
ovf_a  output  1  sticky: lane-A arrival lost at full queue
ovf_b  output  1  sticky: lane-B arrival lost at full queue

Behaviour:
- Decided interface: reset rst, asynchronous, active-high; clock clk.
- Reset (async, any time, including mid-debounce or mid-departure) clears synchronisers, filtered levels, debounce counters, departure counters, queues, Ta, Tb, ovf_a, ovf_b. All outputs are 0 during and after reset.
- Lanes A and B are identical and independent. The rules below are written for lane X (loop_x, Gx, qx, Tx, ovf_x).
- Synchroniser: 2 flops, loop_x -> s1 -> s2.
- Debounce:
  - filt is a register; dcnt is a counter.
  - s2 == filt: dcnt <= 0.
  - s2 != filt: dcnt increments. On the DEBOUNCE_CYCLES-th consecutive mismatching edge, filt <= s2 and dcnt <= 0.
  - Any intervening match restarts the count.
- Arrival: filt_d registers filt. arr = filt & ~filt_d, a one-cycle pulse per filtered rising edge. Falling edges are ignored.
- Departure timer (pcnt):
  - If Gx=1 and qx!=0: pcnt increments each edge. On the DEPART_CYCLES-th such edge, dep=1 for that edge and pcnt <= 0.
  - If Gx=0 or qx==0: pcnt <= 0, dep=0.
  - Dropping Gx mid-count discards partial progress.
- Queue update (per edge):
  - arr & dep: qx unchanged.
  - arr only, qx < max: qx+1.
  - arr only, qx == max: qx unchanged, ovf_x <= 1.
  - dep only: qx-1 (dep implies qx>0; never underflows).
- Tx is registered at the same edge as qx. Tx = (next qx != 0), so Tx always equals (qx != 0).
- Overflow flags: clr_ovf clears ovf_a and ovf_b. A set event in the same cycle as clr_ovf wins (flag stays 1).
- Latency:
  - Raw rising edge, with loop_x held high and sampled first at edge 1: s2=1 after edge 2, filt=1 after edge 2+DEBOUNCE_CYCLES, qx/Tx update after edge 3+DEBOUNCE_CYCLES (edge 7 at defaults).
  - Drain with Gx held high: decrements at edges DEPART_CYCLES, 2*DEPART_CYCLES, ... counted from the first edge with Gx=1 and qx!=0.
- Ga and Gb both high (illegal from the controller): each lane drains independently. No interlock, no error flag.
- Glitches shorter than DEBOUNCE_CYCLES clocks after synchronisation produce no arrival.

Test Plan:
- Reset then idle, loops 0, Ga=Gb=0 for 20 cycles -> Ta=Tb=0, qa=qb=0, ovf_a=ovf_b=0 throughout.
- loop_a 0->1 held, default params -> qa=1 and Ta=1 after exactly edge 7. A second pulse after loop_a low for >=4 cycles, then high -> qa=2.
- loop_b pulses high 3 cycles (<DEBOUNCE_CYCLES) -> qb stays 0, Tb stays 0. Next, a 4-cycle-stable pulse -> qb=1.
- qa=3, Ga=1 held -> qa=2,1,0 at edges 8,16,24 after Ga rise; Ta falls with qa=0. Ga dropped at pcnt=5 then reasserted -> full 8 cycles required again.
- 16 arrivals on lane A with Ga=0 (QUEUE_W=4) -> qa saturates at 15, ovf_a=1 on the 16th. clr_ovf pulsed alone -> ovf_a=0. clr_ovf coincident with a 17th arrival -> ovf_a stays 1.
- Arrival coinciding with a departure edge (qa=2, Ga=1) -> qa stays 2. rst asserted mid-debounce and mid-drain -> all outputs 0 immediately and a fresh full latency is needed after release.
